rtc_bus_secuenciador: RTL and testbench
=======================================

Name: rtc_bus_secuenciador

Overview:
Bus-cycle sequencer for the parallel RTC interface. It accepts one read or write command (address plus optional data) and generates the multiplexed address/data bus timing on the RTC pins: chip select, read and write strobes, and address/data phase. It also drives the tri-state bus driver stage directly downstream through its address/data select, drive enable and read-capture controls. Busy and done flags go back to the upstream control logic.

Parameters:
T_PULSO, 4, length in clk cycles of each bus phase (legal range 1..255).
ANCHO_CNT, 8, phase counter width; must be able to hold T_PULSO.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
iniciar  input  1  command strobe; sampled only in IDLE.
rw  input  1  command type: 1 = read, 0 = write.
dir_in  input  8  RTC register address.
dato_in  input  8  write data (ignored for reads).
direccion  output  8  latched address, to the bus driver.
datoescribir  output  8  latched write data, to the bus driver.
AD  output  1  bus driver select: 0 = address, 1 = data.
escribirdato  output  1  active-low bus drive enable (1 = bus tri-stated).
leerdato  output  1  active-low read-capture strobe to the bus driver.
cs_n  output  1  RTC chip select, active low.
rd_n  output  1  RTC read strobe, active low.
wr_n  output  1  RTC write / address-latch strobe, active low.
ocupado  output  1  high from command accept until return to IDLE.
listo  output  1  one-cycle done pulse.

Behaviour:
- All outputs are registered (Moore). Reset values: cs_n=1, rd_n=1, wr_n=1, AD=0, escribirdato=1, leerdato=1, ocupado=0, listo=0, direccion=0, datoescribir=0, state=IDLE, counter=0.
- States: IDLE, DIR_PULSO, DIR_ESPERA, DAT_PULSO, DAT_ESPERA, FIN.
- IDLE: when iniciar=1, latch rw, dir_in and dato_in. Set ocupado=1 and enter DIR_PULSO on the next edge. Otherwise stay in IDLE.
- Each of DIR_PULSO, DIR_ESPERA, DAT_PULSO and DAT_ESPERA lasts exactly T_PULSO cycles. The counter is loaded on entry and the state advances when the counter expires. FIN lasts 1 cycle, then the block returns to IDLE.
- DIR_PULSO: cs_n=0, AD=0, escribirdato=0 (address driven), wr_n=0.
- DIR_ESPERA: cs_n=0, AD=0, escribirdato=0 (address hold), wr_n=1.
- DAT_PULSO, write command: AD=1, escribirdato=0, wr_n=0.
- DAT_PULSO, read command: AD=1, escribirdato=1 (bus released), rd_n=0. leerdato=0 for exactly one cycle, the last cycle of DAT_PULSO, while rd_n is still 0.
- DAT_ESPERA: cs_n=0, rd_n=1, wr_n=1. For writes, data stays driven (hold). For reads, escribirdato=1.
- FIN: cs_n=1, escribirdato=1, AD=0, listo=1, ocupado=1.
- Back in IDLE: ocupado=0.
- Latency: if iniciar is sampled at edge 0, listo is high during cycle 4*T_PULSO+1. ocupado falls at edge 4*T_PULSO+2.
- The bus is never driven while rd_n=0. escribirdato=0 and rd_n=0 are mutually exclusive in every cycle.
- iniciar while ocupado=1, including during FIN, is ignored and not queued. The command inputs may change freely after accept.
- T_PULSO=1: every phase is a single cycle, and leerdato=0 coincides with the single DAT_PULSO cycle.
- Reset mid-operation: outputs return to reset values immediately (asynchronously), the bus is released and no listo is issued.

Decomposition:
- Package rtc_bus_pkg: state enum, the RW_LEER=1 / RW_ESCRIBIR=0 constants, and the AD_DIR=0 / AD_DATO=1 constants.
- One sub-module, contador_fase: a loadable down-counter (load value T_PULSO-1, output fin_fase). It is instantiated once and reloaded on every phase transition.

Test Plan:
- Reset check: assert reset mid-DAT_PULSO of a write. All outputs go to reset values without waiting for clk, and the block is in IDLE after release.
- Write, T_PULSO=4: iniciar with rw=0, dir_in=8'h21, dato_in=8'h5A. The checks are:
  - cycles 1-4: wr_n=0, AD=0, bus=21.
  - cycles 5-8: wr_n=1, bus still 21.
  - cycles 9-12: wr_n=0, AD=1, bus=5A.
  - cycles 13-16: wr_n=1, bus still 5A.
  - cycle 17: listo=1.
  - cs_n=0 across cycles 1-16.
- Read, T_PULSO=4: rw=1, dir_in=8'h23, with the RTC model returning 8'h37. The checks are:
  - rd_n=0 in cycles 9-12.
  - leerdato=0 only in cycle 12.
  - escribirdato=1 in cycles 9-17.
  - the downstream datoleer equals 8'h37 after cycle 12.
- Busy ignore: pulse iniciar in cycles 3 and 17 of an active command. Exactly one transaction completes, and no second cycle starts until iniciar is seen again in IDLE.
- Back-to-back: hold iniciar high continuously. A new command is accepted on the first IDLE cycle after FIN, giving a 4*T_PULSO+2 cycle period. Check that cs_n returns to 1 for at least 2 cycles between transactions.
- T_PULSO=1 read: phases are 1 cycle each, listo is high in cycle 5, and leerdato=0 coincides with rd_n=0 in cycle 3.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the parallel RTC bus sequencer.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIR_PULSO,
    DIR_ESPERA,
    DAT_PULSO,
    DAT_ESPERA,
    FIN
  } estado_t;

  localparam logic RW_LEER     = 1'b1;
  localparam logic RW_ESCRIBIR = 1'b0;

  localparam logic AD_DIR  = 1'b0;
  localparam logic AD_DATO = 1'b1;

endpackage

// File: rtl/rtc_bus_secuenciador_contador_fase.sv
// Loadable down-counter timing one bus phase; fin_fase marks the last cycle.
module contador_fase #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor,
  output logic             fin_fase
);

  logic [ANCHO-1:0] cuenta_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_reg <= '0;
    end else if (cargar) begin
      cuenta_reg <= valor;
    end else if (cuenta_reg != '0) begin
      cuenta_reg <= cuenta_reg - ANCHO'(1);
    end
  end

  assign fin_fase = (cuenta_reg == '0);

endmodule

// File: rtl/rtc_bus_secuenciador.sv
// Bus-cycle sequencer for the multiplexed RTC interface. Pin outputs are
// registered from the current state, so they trail the state by one cycle.
module rtc_bus_secuenciador
  import rtc_bus_pkg::*;
#(
  parameter int T_PULSO   = 4,
  parameter int ANCHO_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       rw,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  output logic [7:0] direccion,
  output logic [7:0] datoescribir,
  output logic       AD,
  output logic       escribirdato,
  output logic       leerdato,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ocupado,
  output logic       listo
);

  localparam logic [ANCHO_CNT-1:0] CARGA = ANCHO_CNT'(T_PULSO - 1);

  estado_t estado_reg;
  logic    rw_reg;
  logic    fin_fase;
  logic    en_fase;
  logic    cargar;

  assign en_fase = (estado_reg == DIR_PULSO) || (estado_reg == DIR_ESPERA) ||
                   (estado_reg == DAT_PULSO) || (estado_reg == DAT_ESPERA);
  assign cargar  = ((estado_reg == IDLE) && iniciar) || (en_fase && fin_fase);

  contador_fase #(
    .ANCHO(ANCHO_CNT)
  ) u_contador (
    .clk     (clk),
    .reset   (reset),
    .cargar  (cargar),
    .valor   (CARGA),
    .fin_fase(fin_fase)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg   <= IDLE;
      rw_reg       <= RW_ESCRIBIR;
      direccion    <= '0;
      datoescribir <= '0;
      cs_n         <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      AD           <= AD_DIR;
      escribirdato <= 1'b1;
      leerdato     <= 1'b1;
      ocupado      <= 1'b0;
      listo        <= 1'b0;
    end else begin
      case (estado_reg)
        IDLE: begin
          if (iniciar) begin
            rw_reg       <= rw;
            direccion    <= dir_in;
            datoescribir <= dato_in;
            estado_reg   <= DIR_PULSO;
          end
        end
        DIR_PULSO:  if (fin_fase) estado_reg <= DIR_ESPERA;
        DIR_ESPERA: if (fin_fase) estado_reg <= DAT_PULSO;
        DAT_PULSO:  if (fin_fase) estado_reg <= DAT_ESPERA;
        DAT_ESPERA: if (fin_fase) estado_reg <= FIN;
        default:    estado_reg <= IDLE;
      endcase

      // Bus released and strobes idle unless the current state says otherwise.
      cs_n         <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      AD           <= AD_DIR;
      escribirdato <= 1'b1;
      leerdato     <= 1'b1;
      listo        <= 1'b0;
      ocupado      <= 1'b1;

      case (estado_reg)
        IDLE: ocupado <= iniciar;
        DIR_PULSO: begin
          cs_n         <= 1'b0;
          escribirdato <= 1'b0;
          wr_n         <= 1'b0;
        end
        DIR_ESPERA: begin
          cs_n         <= 1'b0;
          escribirdato <= 1'b0;
        end
        DAT_PULSO: begin
          cs_n <= 1'b0;
          AD   <= AD_DATO;
          if (rw_reg == RW_LEER) begin
            rd_n     <= 1'b0;
            leerdato <= ~fin_fase;
          end else begin
            escribirdato <= 1'b0;
            wr_n         <= 1'b0;
          end
        end
        DAT_ESPERA: begin
          cs_n         <= 1'b0;
          AD           <= AD_DATO;
          escribirdato <= (rw_reg == RW_ESCRIBIR) ? 1'b0 : 1'b1;
        end
        default: listo <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_secuenciador.sv
// Self-checking bench: per-cycle pin timing, RTC bus model and completion scoreboard.
module tb_rtc_bus_secuenciador;

  localparam int T4 = 4;
  localparam logic [7:0] VEC_RESET = 8'b1110_1100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iniciar, rw;
  logic [7:0] dir_in, dato_in;
  logic [7:0] direccion4, datoescribir4;
  logic       AD4, escribirdato4, leerdato4, cs_n4, rd_n4, wr_n4, ocupado4, listo4;

  logic       iniciar1, rw1;
  logic [7:0] dir1, dato1;
  logic [7:0] direccion1, datoescribir1;
  logic       AD1, escribirdato1, leerdato1, cs_n1, rd_n1, wr_n1, ocupado1, listo1;

  rtc_bus_secuenciador #(.T_PULSO(T4), .ANCHO_CNT(8)) dut4 (
    .clk(clk), .reset(reset), .iniciar(iniciar), .rw(rw), .dir_in(dir_in), .dato_in(dato_in),
    .direccion(direccion4), .datoescribir(datoescribir4), .AD(AD4), .escribirdato(escribirdato4),
    .leerdato(leerdato4), .cs_n(cs_n4), .rd_n(rd_n4), .wr_n(wr_n4), .ocupado(ocupado4), .listo(listo4)
  );

  rtc_bus_secuenciador #(.T_PULSO(1), .ANCHO_CNT(8)) dut1 (
    .clk(clk), .reset(reset), .iniciar(iniciar1), .rw(rw1), .dir_in(dir1), .dato_in(dato1),
    .direccion(direccion1), .datoescribir(datoescribir1), .AD(AD1), .escribirdato(escribirdato1),
    .leerdato(leerdato1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ocupado(ocupado1), .listo(listo1)
  );

  // Tri-state driver stage plus RTC register file; 8'hFF stands for a floating bus.
  logic [7:0] rtc_mem [256];
  logic [7:0] addr_lat;
  logic [7:0] bus4;
  logic [7:0] datoleer;

  assign bus4 = !escribirdato4 ? (AD4 ? datoescribir4 : direccion4) :
                (!cs_n4 && !rd_n4) ? rtc_mem[addr_lat] : 8'hFF;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) rtc_mem[i] <= 8'h00;
      rtc_mem[8'h23] <= 8'h37;
      addr_lat <= 8'h00;
      datoleer <= 8'h00;
    end else begin
      if (!cs_n4 && !wr_n4) begin
        if (!AD4) addr_lat <= bus4;
        else      rtc_mem[addr_lat] <= bus4;
      end
      if (!leerdato4) datoleer <= bus4;
    end
  end

  typedef struct {
    logic       rw;
    logic [7:0] dir;
    logic [7:0] dato;
  } esperado_t;
  esperado_t sb[$];

  typedef struct {
    logic       rw;
    logic [7:0] dir;
    logic [7:0] dato;
    logic [1:0] modo;   // 0 single pulse, 1 with ignored pulses, 2 iniciar left high
    logic [7:0] leido;
  } vector_t;
  vector_t tabla[7];

  int n_comp = 0;
  int n_err  = 0;

  task automatic comparar(input string nombre, input logic [7:0] real_v, input logic [7:0] esp);
    n_comp++;
    if (real_v !== esp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", nombre, $time, real_v, esp);
    end
  endtask

  // Order: {cs_n, rd_n, wr_n, AD, escribirdato, leerdato, ocupado, listo}
  function automatic logic [7:0] exp_vec(input int k, input logic rw_c, input int t);
    logic cs = 1, rd = 1, wr = 1, ad = 0, esc = 1, lee = 1, ocu = 0, lis = 0;
    int fase, pos;
    if (k == 0) begin
      ocu = 1;
    end else if (k <= 4 * t) begin
      fase = (k - 1) / t;
      pos  = (k - 1) % t;
      ocu  = 1;
      cs   = 0;
      case (fase)
        0: begin esc = 0; wr = 0; end
        1: esc = 0;
        2: begin
          ad = 1;
          if (rw_c) begin rd = 0; lee = (pos == t - 1) ? 1'b0 : 1'b1; end
          else begin esc = 0; wr = 0; end
        end
        default: begin ad = 1; esc = rw_c; end
      endcase
    end else if (k == 4 * t + 1) begin
      ocu = 1;
      lis = 1;
    end
    return {cs, rd, wr, ad, esc, lee, ocu, lis};
  endfunction

  function automatic logic [7:0] obs4();
    return {cs_n4, rd_n4, wr_n4, AD4, escribirdato4, leerdato4, ocupado4, listo4};
  endfunction

  function automatic logic [7:0] obs1();
    return {cs_n1, rd_n1, wr_n1, AD1, escribirdato1, leerdato1, ocupado1, listo1};
  endfunction

  // Monitor: bus contention every cycle, and scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (!escribirdato4 && !rd_n4) begin
        n_comp++;
        n_err++;
        $display("FAIL bus_conflict @%0t: escribirdato=0 with rd_n=0", $time);
      end
      if (listo4) begin
        if (sb.size() == 0) begin
          n_comp++;
          n_err++;
          $display("FAIL listo_extra @%0t: got listo with no command pending", $time);
        end else begin
          esperado_t e;
          e = sb.pop_front();
          if (e.rw) comparar($sformatf("lectura_%h", e.dir), datoleer, e.dato);
          else      comparar($sformatf("escritura_%h", e.dir), rtc_mem[e.dir], e.dato);
        end
      end
    end
  end

  task automatic comando(input logic rw_c, input logic [7:0] d, input logic [7:0] v,
                         input logic [1:0] modo, input logic [7:0] leido);
    esperado_t e;
    int ultimo;
    rw      = rw_c;
    dir_in  = d;
    dato_in = v;
    iniciar = 1'b1;
    e.rw   = rw_c;
    e.dir  = d;
    e.dato = rw_c ? leido : v;
    sb.push_back(e);
    ultimo = (modo == 2'd2) ? 4 * T4 + 1 : 4 * T4 + 3;
    for (int k = 0; k <= ultimo; k++) begin
      @(negedge clk);
      comparar($sformatf("pines_%h_c%0d", d, k), obs4(), exp_vec(k, rw_c, T4));
      if (k >= 1 && k <= 2 * T4)
        comparar($sformatf("bus_dir_c%0d", k), bus4, d);
      else if (!rw_c && k > 2 * T4 && k <= 4 * T4)
        comparar($sformatf("bus_dato_c%0d", k), bus4, v);
      if (modo != 2'd2) iniciar = (modo == 2'd1 && (k == 2 || k == 16)) ? 1'b1 : 1'b0;
      if (k == 0) begin
        rw      = 1'($urandom);
        dir_in  = 8'($urandom);
        dato_in = 8'($urandom);
      end
    end
    $display("txn rw=%0d dir=%h dato=%h modo=%0d done", rw_c, d, v, modo);
  endtask

  initial begin
    tabla[0] = '{1'b0, 8'h21, 8'h5A, 2'd0, 8'h00};
    tabla[1] = '{1'b1, 8'h23, 8'h00, 2'd0, 8'h37};
    tabla[2] = '{1'b1, 8'h21, 8'h00, 2'd0, 8'h5A};
    tabla[3] = '{1'b0, 8'h40, 8'hC3, 2'd1, 8'h00};
    tabla[4] = '{1'b0, 8'h41, 8'h0F, 2'd2, 8'h00};
    tabla[5] = '{1'b1, 8'h40, 8'h00, 2'd0, 8'hC3};
    tabla[6] = '{1'b1, 8'h41, 8'h00, 2'd0, 8'h0F};

    reset = 1'b1;
    iniciar = 1'b0; rw = 1'b0; dir_in = 8'h00; dato_in = 8'h00;
    iniciar1 = 1'b0; rw1 = 1'b0; dir1 = 8'h00; dato1 = 8'h00;
    repeat (3) @(negedge clk);
    comparar("reset_pines", obs4(), VEC_RESET);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of the data strobe of a write.
    rw = 1'b0; dir_in = 8'h21; dato_in = 8'hAA; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (10) @(negedge clk);
    comparar("pre_reset_c10", obs4(), exp_vec(10, 1'b0, T4));
    #2 reset = 1'b1;
    #1;
    comparar("reset_async_pines", obs4(), VEC_RESET);
    comparar("reset_async_dir", direccion4, 8'h00);
    comparar("reset_async_dato", datoescribir4, 8'h00);
    comparar("reset_async_t1", obs1(), VEC_RESET);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      comparar($sformatf("idle_post_reset_%0d", i), obs4(), VEC_RESET);
    end
    $display("txn reset mid-write done");

    for (int i = 0; i < 7; i++)
      comando(tabla[i].rw, tabla[i].dir, tabla[i].dato, tabla[i].modo, tabla[i].leido);

    // Single-cycle phases on the T_PULSO=1 instance.
    rw1 = 1'b1; dir1 = 8'h23; dato1 = 8'h99; iniciar1 = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      comparar($sformatf("t1_pines_c%0d", k), obs1(), exp_vec(k, 1'b1, 1));
      iniciar1 = 1'b0;
    end
    comparar("t1_dir", direccion1, 8'h23);
    comparar("t1_dato", datoescribir1, 8'h99);
    $display("txn T_PULSO=1 read done");

    n_comp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_pendiente: got %0d commands without listo, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
